// File: rtl/seq_accumulator.sv
// Running-sum accumulator: adds n_terms unsigned operands taken over a valid/ready
// handshake, then pulses done. Define SEQ_ACC_SAT_EN for a saturating sum instead of wrapping.
module seq_accumulator #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] n_terms,
    input  logic               a_valid,
    input  logic [WIDTH-1:0]   a,
    output logic               a_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [COUNT_W-1:0] remaining;
    logic [WIDTH:0]     total;
    logic               xfer;

    // Reduce the carry-extended total to the stored sum for this build.
    function automatic logic [WIDTH-1:0] next_sum(input logic [WIDTH:0] t);
`ifdef SEQ_ACC_SAT_EN
        return t[WIDTH] ? {WIDTH{1'b1}} : t[WIDTH-1:0];
`else
        return t[WIDTH-1:0];
`endif
    endfunction

    assign total   = {1'b0, sum} + {1'b0, a};
    assign xfer    = a_valid && (state == ACC);
    assign a_ready = (state == ACC);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sum       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sum       <= '0;
                        ovf       <= 1'b0;
                        remaining <= n_terms;
                        state     <= (n_terms != '0) ? ACC : DONE;
                    end
                end
                ACC: begin
                    if (xfer) begin
                        sum       <= next_sum(total);
                        ovf       <= ovf | total[WIDTH];
                        remaining <= remaining - 1'b1;
                        if (remaining == COUNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_accumulator.sv
// Self-checking bench for seq_accumulator: directed scenarios plus randomized runs
// compared against an arithmetic model of the final sum and overflow flag.
module tb_seq_accumulator;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] n_terms = '0;
    logic          a_valid = 1'b0;
    logic [W-1:0]  a = '0;
    logic          a_ready;
    logic [W-1:0]  sum;
    logic          busy;
    logic          done;
    logic          ovf;

    int n_pass = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [W-1:0] ops    [16];
    int           stalls [16];

    seq_accumulator #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .n_terms (n_terms),
        .a_valid (a_valid),
        .a       (a),
        .a_ready (a_ready),
        .sum     (sum),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Expected sum for a given true (unbounded) total of the run so far.
    function automatic logic [W-1:0] model_sum(input int unsigned t);
`ifdef SEQ_ACC_SAT_EN
        return (t > 255) ? 8'hFF : W'(t);
`else
        return W'(t % 256);
`endif
    endfunction

    function automatic logic model_ovf(input int unsigned t);
        return t > 255;
    endfunction

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        start   = 1'b1;
        n_terms = CW'(n);
        tick();
        start   = 1'b0;
        n_terms = '0;
    endtask

    task automatic feed(input logic [W-1:0] val);
        check_bit("a_ready_acc", a_ready, 1'b1);
        check_bit("busy_acc", busy, 1'b1);
        a_valid = 1'b1;
        a       = val;
        tick();
        a_valid = 1'b0;
        a       = $urandom_range(0, 255);
    endtask

    // One complete run using ops[0..n-1] and stalls[0..n-1].
    task automatic do_run(input int n);
        int unsigned total;
        total = 0;
        start_run(n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < stalls[i]; k++) begin
                a = $urandom_range(0, 255);
                tick();
                check_val("stall_sum", sum, model_sum(total));
            end
            feed(ops[i]);
            total += ops[i];
            check_val("partial_sum", sum, model_sum(total));
            if (i < n - 1) check_bit("done_early", done, 1'b0);
        end
        check_bit("done_pulse", done, 1'b1);
        check_bit("busy_done", busy, 1'b1);
        check_bit("a_ready_done", a_ready, 1'b0);
        check_val("final_sum", sum, model_sum(total));
        check_bit("final_ovf", ovf, model_ovf(total));
        tick();
        check_bit("done_cleared", done, 1'b0);
        check_bit("busy_idle", busy, 1'b0);
        check_bit("a_ready_idle", a_ready, 1'b0);
        check_val("sum_held", sum, model_sum(total));
    endtask

    initial begin
        // Reset for two cycles
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_sum", sum, 8'h00);
        check_bit("rst_ovf", ovf, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_a_ready", a_ready, 1'b0);

        for (int i = 0; i < 16; i++) stalls[i] = 0;

        ops[0] = 8'h17; ops[1] = 8'h01; ops[2] = 8'h7F;
        do_run(3);
        check_val("t2_sum", sum, 8'h97);
        check_bit("t2_ovf", ovf, 1'b0);

        ops[0] = 8'hF0; ops[1] = 8'h20;
        do_run(2);
`ifdef SEQ_ACC_SAT_EN
        check_val("t3_sum_sat", sum, 8'hFF);
`else
        check_val("t3_sum_wrap", sum, 8'h10);
`endif
        check_bit("t3_ovf", ovf, 1'b1);

        ops[0] = 8'h05; ops[1] = 8'h03; stalls[1] = 5;
        do_run(2);
        check_val("t4_sum", sum, 8'h08);
        stalls[1] = 0;

        do_run(0);
        check_val("t5_empty_sum", sum, 8'h00);

        // start during ACC must not reload the term counter
        start_run(2);
        feed(8'h11);
        start   = 1'b1;
        n_terms = 4'd5;
        tick();
        start   = 1'b0;
        n_terms = '0;
        check_bit("t5_start_ignored", done, 1'b0);
        feed(8'h22);
        check_bit("t5_done_after_2", done, 1'b1);
        check_val("t5_sum", sum, 8'h33);
        tick();
        check_bit("t5_idle", busy, 1'b0);

        // Abort mid-run with reset
        start_run(4);
        feed(8'h40);
        feed(8'h41);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t6_rst_sum", sum, 8'h00);
        check_bit("t6_rst_busy", busy, 1'b0);
        check_bit("t6_rst_done", done, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_bit("t6_no_done", done, 1'b0);
        end
        ops[0] = 8'h2A;
        do_run(1);
        check_val("t6_fresh_sum", sum, 8'h2A);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                ops[i]    = W'($urandom_range(0, 255));
                stalls[i] = $urandom_range(0, 2);
            end
            do_run(n);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
